// File: rtl/css_pkg.sv
// rtl/css_pkg.sv - shared constants, index types and FSM states for the CSS window sequencer
package css_pkg;

    localparam int KERNEL_SIZE    = 3;
    localparam int DEF_MAP_WIDTH  = 1024;
    localparam int DEF_MAP_HEIGHT = 1024;
    localparam int DEF_CW         = $clog2(DEF_MAP_WIDTH + 1);
    localparam int DEF_RW         = $clog2(DEF_MAP_HEIGHT + 1);

    typedef logic [DEF_CW-1:0] col_idx_t;
    typedef logic [DEF_RW-1:0] row_idx_t;

    typedef enum logic {
        IDLE,
        RUN
    } ctrl_state_e;

endpackage

// File: rtl/css_pos_counter.sv
// rtl/css_pos_counter.sv - column/band position counter with runtime wrap limits
module css_pos_counter #(
    parameter int CW = 11,
    parameter int RW = 11
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] col_max,
    input  logic [RW-1:0] band_max,
    output logic [CW-1:0] col,
    output logic [RW-1:0] band,
    output logic          col_last,
    output logic          band_last
);

    assign col_last  = (col == col_max);
    assign band_last = (band == band_max);

    always_ff @(posedge clk) begin
        if (rst_in || clr) begin
            col  <= '0;
            band <= '0;
        end else if (inc) begin
            if (col_last) begin
                col  <= '0;
                // Wrap the band as well so the counter rests at 0 after the last position.
                band <= band_last ? '0 : band + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/css_window_ctrl.sv
// rtl/css_window_ctrl.sv - load/shift sequencer presenting 3x3 CSS windows with (row, col)
module css_window_ctrl #(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int KERNEL_SIZE        = 3,
    localparam int CW = $clog2(FEATURE_MAP_WIDTH + 1),
    localparam int RW = $clog2(FEATURE_MAP_HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          start,
    input  logic [CW-1:0] cfg_width,
    input  logic [RW-1:0] cfg_height,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          LE,
    output logic          shift,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-2:0] win_col,
    output logic [RW-2:0] win_row
);

    import css_pkg::*;

    if (KERNEL_SIZE != css_pkg::KERNEL_SIZE) begin : g_kernel_check
        $error("css_window_ctrl supports only a 3x3 kernel");
    end

    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] col_max_q;
    logic [RW-1:0] band_max_q;
    logic          i_full_q, win_pending_q, all_in_q, done_q, cfg_err_q;
    logic [1:0]    o_cnt_q;

    logic [CW-1:0] in_col, sh_col;
    logic [RW-1:0] in_band, sh_band;
    logic          in_col_last, in_band_last, sh_col_last, sh_band_last;
    logic          cfg_legal, handshake, frame_end, clr, sh_inc;

    assign cfg_legal = (cfg_width >= CW'(3)) && (cfg_width <= CW'(FEATURE_MAP_WIDTH)) &&
                       (cfg_height >= RW'(3)) && (cfg_height <= RW'(FEATURE_MAP_HEIGHT));

    assign busy      = (state_q == RUN);
    assign shift     = busy && i_full_q && (!win_pending_q || win_ready);
    assign in_ready  = busy && !all_in_q && (!i_full_q || shift);
    assign LE        = in_valid && in_ready;
    assign handshake = win_pending_q && win_ready;
    assign frame_end = handshake && sh_col_last && sh_band_last;
    assign clr       = !busy;
    // The very first shift of a frame fills o with column 0; sh_col already reads 0.
    assign sh_inc    = shift && (o_cnt_q != 2'd0);

    assign win_valid = win_pending_q;
    assign win_col   = (CW-1)'(sh_col - CW'(2));
    assign win_row   = (RW-1)'(sh_band);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

    css_pos_counter #(.CW(CW), .RW(RW)) u_in_pos (
        .clk       (clk),
        .rst_in    (rst_in),
        .clr       (clr),
        .inc       (LE),
        .col_max   (col_max_q),
        .band_max  (band_max_q),
        .col       (in_col),
        .band      (in_band),
        .col_last  (in_col_last),
        .band_last (in_band_last)
    );

    css_pos_counter #(.CW(CW), .RW(RW)) u_sh_pos (
        .clk       (clk),
        .rst_in    (rst_in),
        .clr       (clr),
        .inc       (sh_inc),
        .col_max   (col_max_q),
        .band_max  (band_max_q),
        .col       (sh_col),
        .band      (sh_band),
        .col_last  (sh_col_last),
        .band_last (sh_band_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && cfg_legal) state_d = RUN;
            RUN:  if (frame_end)          state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            col_max_q     <= '0;
            band_max_q    <= '0;
            i_full_q      <= 1'b0;
            win_pending_q <= 1'b0;
            all_in_q      <= 1'b0;
            o_cnt_q       <= 2'd0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            done_q    <= frame_end;
            cfg_err_q <= (state_q == IDLE) && start && !cfg_legal;
            if ((state_q == IDLE) && start && cfg_legal) begin
                col_max_q  <= cfg_width - CW'(1);
                band_max_q <= cfg_height - RW'(3);
            end
            if (clr) begin
                i_full_q      <= 1'b0;
                win_pending_q <= 1'b0;
                all_in_q      <= 1'b0;
                o_cnt_q       <= 2'd0;
            end else begin
                if (LE)         i_full_q <= 1'b1;
                else if (shift) i_full_q <= 1'b0;
                if (LE && in_col_last && in_band_last) all_in_q <= 1'b1;
                if (shift) begin
                    if ((o_cnt_q == 2'd0) || sh_col_last) o_cnt_q <= 2'd1;
                    else if (o_cnt_q != 2'd3)             o_cnt_q <= o_cnt_q + 2'd1;
                end
                // A window exists once o holds three columns of the same band.
                if (shift)          win_pending_q <= (o_cnt_q >= 2'd2) && !sh_col_last;
                else if (handshake) win_pending_q <= 1'b0;
            end
        end
    end

    a_in_pos: assert property (@(posedge clk) disable iff (rst_in || !busy)
        (in_col <= col_max_q) && (in_band <= band_max_q));

endmodule

// File: tb/tb_css_window_ctrl.sv
// tb/tb_css_window_ctrl.sv - randomized self-checking bench for css_window_ctrl
module tb_css_window_ctrl;

    import css_pkg::*;

    localparam int FMW = 1024;
    localparam int FMH = 1024;
    localparam int CW  = $clog2(FMW + 1);
    localparam int RW  = $clog2(FMH + 1);

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          start = 1'b0;
    col_idx_t      cfg_width = '0;
    row_idx_t      cfg_height = '0;
    logic          in_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          busy, done, cfg_err, in_ready, LE, shift, win_valid;
    logic [CW-2:0] win_col;
    logic [RW-2:0] win_row;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    css_window_ctrl #(
        .FEATURE_MAP_WIDTH  (FMW),
        .FEATURE_MAP_HEIGHT (FMH),
        .KERNEL_SIZE        (3)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .LE         (LE),
        .shift      (shift),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_col    (win_col),
        .win_row    (win_row)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One frame of W x H; windows expected in raster order (row, col), W-2 per band.
    task automatic run_frame(input int w, input int h, input int pin, input int pout,
                             input int hold, input bit poke);
        int exp_r[$];
        int exp_c[$];
        int n, idx, acc, dn, errs, cyc, pc, pr;
        bit stall;
        for (int r = 0; r <= h - 3; r++)
            for (int c = 0; c <= w - 3; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        n = exp_r.size();
        idx = 0; acc = 0; dn = 0; errs = 0; cyc = 0; pc = 0; pr = 0; stall = 1'b0;

        @(negedge clk);
        cfg_width = CW'(w); cfg_height = RW'(h); start = 1'b1;
        in_valid = 1'b0; win_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_busy", busy, 1);
        check("start_cfg_err", cfg_err, 0);

        while (idx < n && cyc < 4000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(99) < pin);
            win_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pout);
            if (poke && cyc == 4) begin
                start = 1'b1; cfg_width = CW'(3); cfg_height = RW'(3);
            end else begin
                start = 1'b0;
            end
            #1;
            if (stall) begin
                check("hold_valid", win_valid, 1);
                check("hold_col", win_col, pc);
                check("hold_row", win_row, pr);
            end
            if (acc >= w * (h - 2)) check("in_ready_after_all", in_ready, 0);
            if (win_valid) check("win_complete", acc >= exp_r[idx] * w + exp_c[idx] + 3, 1);
            if (win_valid && win_ready) begin
                check("win_row", win_row, exp_r[idx]);
                check("win_col", win_col, exp_c[idx]);
                idx++;
            end
            if (hold > 0 && cyc == hold - 1) begin
                check("bp_valid", win_valid, 1);
                check("bp_col", win_col, 0);
                check("bp_shift", shift, 0);
                check("bp_in_ready", in_ready, 0);
            end
            if (LE) acc++;
            if (done) dn++;
            if (cfg_err) errs++;
            stall = win_valid && !win_ready;
            pc = int'(win_col);
            pr = int'(win_row);
            cyc++;
        end
        check("window_count", idx, n);
        if (pin == 100 && pout == 100 && hold == 0)
            check("throughput_cycles", cyc, w * (h - 2) + 2);

        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1; win_ready = 1'b1; start = 1'b0;
            #1;
            check("tail_no_window", win_valid, 0);
            if (LE) acc++;
            if (done) dn++;
            if (cfg_err) errs++;
        end
        in_valid = 1'b0;
        check("le_count", acc, w * (h - 2));
        check("done_count", dn, 1);
        check("cfg_err_count", errs, 0);
        check("busy_end", busy, 0);
    endtask

    task automatic cfg_bad(input int w, input int h);
        @(negedge clk);
        cfg_width = CW'(w); cfg_height = RW'(h); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clk);
        #1;
        check("cfg_err_clear", cfg_err, 0);
        check("cfg_err_idle", busy, 0);
    endtask

    initial begin
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_le", LE, 0);
        check("rst_shift", shift, 0);
        @(negedge clk);
        rst_in = 1'b0;
        in_valid = 1'b0;

        run_frame(5, 4, 100, 100, 0, 1'b0);
        run_frame(3, 3, 100, 100, 0, 1'b0);
        run_frame(6, 3, 100, 100, 10, 1'b0);
        run_frame(7, 5, 50, 100, 0, 1'b0);
        run_frame(6, 4, 60, 60, 0, 1'b1);

        @(negedge clk);
        cfg_width = CW'(8); cfg_height = RW'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_win_valid", win_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_le", LE, 0);
        in_valid = 1'b0; win_ready = 1'b0;
        run_frame(4, 4, 100, 100, 0, 1'b0);

        for (int k = 0; k < 6; k++)
            run_frame(int'($urandom_range(12, 3)), int'($urandom_range(7, 3)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, 1'b0);

        cfg_bad(2, 5);
        cfg_bad(5, FMH + 1);
        cfg_bad(FMW + 1, 5);
        cfg_bad(5, 2);
        run_frame(3, 4, 100, 100, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
